// File: rtl/pdatapath.sv
// pdatapath: 2^RA x WIDTH register file with a function unit, valid/ready control-word intake,
// and stalling loads / strobed stores. Define PDATAPATH_SHIFT_EN to build the B>>1 / B<<1 shifter.
module pdatapath #(
    parameter int WIDTH = 16,
    parameter int RA    = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3*RA+7:0]   CTRWRD,
    input  logic              CTRV,
    output logic              CTRRDY,
    input  logic [WIDTH-1:0]  Cin,
    input  logic [WIDTH-1:0]  Din,
    input  logic              DVALID,
    output logic [WIDTH-1:0]  Adrout,
    output logic [WIDTH-1:0]  Dout,
    output logic              MRD,
    output logic              MWR,
    output logic              V,
    output logic              C,
    output logic              N,
    output logic              Z
);
    localparam int NREG = 1 << RA;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_adrout;
    logic [WIDTH-1:0] r_dout;
    logic             r_mwr;
    logic             r_v;
    logic             r_c;
    logic             r_n;
    logic             r_z;
    logic [RA-1:0]    r_ld_da;
    logic             r_ld_rw;

    logic [RA-1:0]    w_da;
    logic [RA-1:0]    w_aa;
    logic [RA-1:0]    w_ba;
    logic             w_mb;
    logic [3:0]       w_fs;
    logic             w_md;
    logic             w_rw;
    logic             w_mw;

    logic [WIDTH-1:0] w_busa;
    logic [WIDTH-1:0] w_busb;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_f;
    logic             w_c;
    logic             w_v;

    logic             w_accept;
    logic             w_alu;
    logic             w_store;
    logic             w_load;
    logic             w_ld_done;

    assign {w_da, w_aa, w_ba, w_mb, w_fs, w_md, w_rw, w_mw} = CTRWRD;

    assign w_busa = r_regs[w_aa];
    assign w_busb = w_mb ? Cin : r_regs[w_ba];

    assign w_accept  = CTRV && (r_state == IDLE);
    assign w_alu     = w_accept && !w_md;
    assign w_store   = w_alu && w_mw;
    assign w_load    = w_accept && w_md;
    assign w_ld_done = (r_state == LOAD) && DVALID;

    // Second adder operand and carry-in for the arithmetic group (FS 0000-0111).
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_y   = '0;
        w_cin = 1'b0;
        case (w_fs)
            4'b0001: w_cin = 1'b1;
            4'b0010: w_y = w_busb;
            4'b0011: begin w_y = w_busb;  w_cin = 1'b1; end
            4'b0100: w_y = ~w_busb;
            4'b0101: begin w_y = ~w_busb; w_cin = 1'b1; end
            4'b0110: w_y = '1;
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_busa} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_f = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        if (!w_fs[3]) begin
            w_f = w_sum[WIDTH-1:0];
            w_c = w_sum[WIDTH];
            w_v = (w_busa[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_busa[WIDTH-1]);
        end else begin
            case (w_fs[2:0])
                3'b000:  w_f = w_busa & w_busb;
                3'b001:  w_f = w_busa | w_busb;
                3'b010:  w_f = w_busa ^ w_busb;
                3'b011:  w_f = ~w_busa;
                3'b100:  w_f = w_busb;
`ifdef PDATAPATH_SHIFT_EN
                3'b101:  w_f = {1'b0, w_busb[WIDTH-1:1]};
                3'b110:  w_f = {w_busb[WIDTH-2:0], 1'b0};
`endif
                default: w_f = '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = LOAD;
            LOAD:    if (DVALID) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_adrout <= '0;
            r_dout   <= '0;
            r_mwr    <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_ld_da  <= '0;
            r_ld_rw  <= 1'b0;
        end else begin
            r_mwr <= w_store;
            if (w_alu) begin
                if (w_rw) r_regs[w_da] <= w_f;
                r_v <= w_v;
                r_c <= w_c;
                r_n <= w_f[WIDTH-1];
                r_z <= (w_f == '0);
            end
            if (w_store) r_dout <= w_busb;
            if (w_store || w_load) r_adrout <= w_busa;
            if (w_load) begin
                r_ld_da <= w_da;
                r_ld_rw <= w_rw;
            end
            if (w_ld_done && r_ld_rw) r_regs[r_ld_da] <= Din;
        end
    end

    assign CTRRDY = (r_state == IDLE);
    assign MRD    = (r_state == LOAD);
    assign MWR    = r_mwr;
    assign Adrout = r_adrout;
    assign Dout   = r_dout;
    assign V      = r_v;
    assign C      = r_c;
    assign N      = r_n;
    assign Z      = r_z;

endmodule

// File: doc/pdatapath.md
# pdatapath

Parametrised successor to the fixed 16-bit, 8-register datapath. It holds a 2^RA-entry register file and a WIDTH-bit function unit, and decodes a control word accepted over a valid/ready handshake. Memory loads stall on a data-valid handshake and stores raise a one-cycle write strobe. It sits between the microprogram sequencer (which supplies CTRWRD and Cin) and the memory interface (Adrout, Dout, Din).

## Interface
- WIDTH, 16: data path and register width (≥4).
- RA, 3: register address bits; register file has 2^RA entries.
- CW, 3*RA+8 (derived, not overridable): control word width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CTRWRD  in  CW  control word. Fields, MSB first:
  - DA[RA]
  - AA[RA]
  - BA[RA]
  - MB
  - FS[4]
  - MD
  - RW
  - MW (LSB)
- CTRV  in  1  control word valid.
- CTRRDY  out  1  datapath can accept a control word.
- Cin  in  WIDTH  constant operand, used when MB=1.
- Din  in  WIDTH  memory read data.
- DVALID  in  1  Din valid; only honoured while a load is pending.
- Adrout  out  WIDTH  registered memory address.
- Dout  out  WIDTH  registered memory write data.
- MRD  out  1  load pending / read request.
- MWR  out  1  one-cycle store strobe.
- V, C, N, Z  out  1 each  registered status flags.

## Operation
- Accept = CTRV & CTRRDY at a rising edge. CTRRDY = (state == IDLE), combinational from state.
- Operand reads are combinational from the register file:
  - busA = R[AA].
  - busB = MB ? Cin : R[BA].
- FSM states: IDLE, LOAD.
- **ALU op (MD=0), accepted in IDLE:** F = FU(FS, busA, busB). If RW, R[DA] ← F. V, C, N, Z update. State stays IDLE.
- **Store (MW=1, MD=0):** executes the ALU op as above in parallel. Also Adrout ← busA, Dout ← busB, MWR ← 1 for exactly one cycle.
- **Load (MD=1):** MW is ignored, and flags and register file are not touched at accept. Adrout ← busA, MRD ← 1. DA and RW are latched. State → LOAD.
- **In LOAD:** when DVALID=1, if latched RW then R[latched DA] ← Din. MRD ← 0, state → IDLE. Without DVALID the FSM waits indefinitely and CTRRDY stays 0.
- **FS codes (arithmetic modulo 2^WIDTH):**
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A+~B+1
  - 0110 A−1
  - 0111 A
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B
  - 1101 B>>1 (logical)
  - 1110 B<<1
  - 1111 reserved; F=0
- **Flags:**
  - N = F[WIDTH−1]; Z = (F == 0).
  - C = carry out of the WIDTH-bit adder for 0000–0111. For 0110, carry of A + all-ones.
  - V = signed overflow of the same adder for 0000–0111.
  - For 1000–1111: C = 0, V = 0.
- **Register file:** the write takes effect at the edge. A read of DA in the same cycle returns the old value. Every register, including R0, is ordinary.
- **Reset:** all registers, Adrout, Dout, MRD, MWR, V, C, N and Z go to 0, and state → IDLE. CTRRDY = 1 in the first cycle after reset. Reset during LOAD abandons the load with no register write; reset wins over a simultaneous DVALID.
- **Idle cycles:** when no word is accepted, Adrout and Dout hold their values, MWR = 0, and flags hold.

## Timing
- ALU op: result is visible in R[DA] and on the flags one cycle after the accept edge. Throughput is 1 word per cycle.
- Store: Adrout, Dout and MWR are valid in the cycle after the accept edge; MWR deasserts one cycle later unless another store is accepted.
- Load: MRD and Adrout are valid from the cycle after the accept edge. If DVALID is high in the first LOAD cycle, R[DA] is written at that edge and CTRRDY returns to 1 next cycle. Minimum load latency is 2 cycles, accept to the next accept.
- DVALID seen in IDLE is ignored.
- CTRWRD must be held stable only at the accept edge.

## Configuration
- PDATAPATH_SHIFT_EN: when defined, FS 1101/1110 perform shifts as listed. When undefined, the shifter is not built and 1101/1110 behave as 1111 (F=0, Z=1, N=C=V=0).

## Test plan
- Reset, then R1 ← Cin=0x0005 (FS=1100, MB=1, RW=1), then R2 ← R1+R1 (FS=0010) → R2=0x000A, Z=0, N=0, C=0, V=0, CTRRDY=1 throughout.
- WIDTH=16: R3=0x7FFF, R3+1 (FS=0001) → 0x8000, V=1, N=1, C=0. Then 0xFFFF+1 → 0x0000, Z=1, C=1, V=0.
- Store with AA=R1=0x0005, BA=R2=0x000A, MW=1 → one cycle later Adrout=0x0005, Dout=0x000A, MWR=1 for one cycle.
- Load with DA=R4, DVALID held off 3 cycles then high with Din=0x1234 → CTRRDY=0 for 4 cycles, MRD=1 for 4 cycles, R4=0x1234, flags unchanged.
- RESET asserted while in LOAD, coincident with DVALID → R[DA] is unwritten, MRD=0, CTRRDY=1 next cycle, all registers 0.
- Build with RA=4, WIDTH=8, without PDATAPATH_SHIFT_EN: write R15, and FS=1110 → R15 written correctly, F=0, Z=1.
